// File: rtl/matrix_writer_pkg.sv
// rtl/matrix_writer_pkg.sv - shared state encoding and default sizing for the matrix writer
package matrix_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEF_WORDS = 4;
  localparam int DEF_AW    = 4;

  // Entry counter must be able to hold WORDS itself, not just WORDS-1.
  function automatic int count_width(input int words);
    return (words < 1) ? 1 : $clog2(words + 1);
  endfunction

endpackage

// File: rtl/ram16x8.sv
// rtl/ram16x8.sv - byte-wide memory with synchronous write and combinational read
module ram16x8
  import matrix_writer_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_writer.sv
// rtl/matrix_writer.sv - accepts WORDS bytes from a valid/ready source and writes them to consecutive addresses
module matrix_writer
  import matrix_writer_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_address,
  input  logic [7:0]    data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic [AW-1:0] address_to_memory,
  output logic [7:0]    data_to_memory,
  output logic          mem_write,
  output logic          busy,
  output logic          done
);

  localparam int CW = count_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t        state;
  logic [AW-1:0] addr;
  logic [CW-1:0] count;
  logic [7:0]    data_reg;

  // Outputs are registered alongside the state, so each is set on entry to the state that owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      data_reg   <= '0;
      data_ready <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr       <= start_address;
            count      <= '0;
            state      <= RECV;
            data_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RECV: begin
          if (data_valid) begin
            data_reg   <= data_in;
            state      <= WRITE;
            data_ready <= 1'b0;
            mem_write  <= 1'b1;
          end
        end
        WRITE: begin
          mem_write <= 1'b0;
          addr      <= addr + AW'(1);
          count     <= count + CW'(1);
          if (count == LAST) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= RECV;
            data_ready <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign address_to_memory = addr;
  assign data_to_memory    = data_reg;

endmodule

// File: tb/tb_matrix_writer.sv
// tb/tb_matrix_writer.sv - directed table-driven bench for matrix_writer with a ram16x8 behind it
module tb_matrix_writer;
  import matrix_writer_pkg::*;

  localparam int WORDS = 4;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [7:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [AW-1:0] address_to_memory;
  logic [7:0]    data_to_memory;
  logic          mem_write;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr = '0;
  logic [7:0]    rdata;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_n = 0;
  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_data[$];
  int            wr_cyc[$];

  typedef struct packed {
    logic [AW-1:0]               sa;
    logic [WORDS-1:0][7:0]       d;
    logic [WORDS-1:0][AW-1:0]    ea;
    int                          gap;
    logic                        restart;
  } vec_t;

  vec_t vecs[4];

  matrix_writer #(.WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .address_to_memory(address_to_memory), .data_to_memory(data_to_memory),
    .mem_write(mem_write), .busy(busy), .done(done)
  );

  ram16x8 #(.AW(AW)) u_ram (
    .clk(clk), .we(mem_write), .waddr(address_to_memory), .wdata(data_to_memory),
    .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr.push_back(address_to_memory);
      wr_data.push_back(data_to_memory);
      wr_cyc.push_back(cyc);
    end
    if (done) done_n++;
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [AW-1:0] sa, input logic [31:0] d,
                              input logic [15:0] ea, input int gap, input logic restart);
    vec_t v;
    v.sa = sa; v.d = d; v.ea = ea; v.gap = gap; v.restart = restart;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ram(input logic [AW-1:0] a, input logic [7:0] exp);
    raddr = a;
    #1;
    check($sformatf("ram[%0d]", a), rdata, exp);
  endtask

  task automatic do_start(input logic [AW-1:0] sa);
    start = 1'b1;
    start_address = sa;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("ready_after_start", data_ready, 1'b1);
  endtask

  task automatic offer(input logic [7:0] b, input int gap, input logic restart_here);
    int n = 0;
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", data_ready, 1'b1);
    if (restart_here) begin
      start = 1'b1;
      start_address = 4'd8;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      start = 1'b0;
      check("gap_ready", data_ready, 1'b1);
      check("gap_no_write", mem_write, 1'b0);
    end
    data_valid = 1'b1;
    data_in = b;
    @(negedge clk);
    data_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("busy_in_finish", busy, 1'b0);
  endtask

  task automatic check_log(input vec_t v, input int wb, input int db);
    check("write_count", wr_addr.size() - wb, WORDS);
    check("done_count", done_n - db, 1);
    if (wr_addr.size() - wb == WORDS) begin
      for (int i = 0; i < WORDS; i++) begin
        check($sformatf("wr_addr%0d", i), wr_addr[wb+i], v.ea[i]);
        check($sformatf("wr_data%0d", i), wr_data[wb+i], v.d[i]);
        if (i > 0) check($sformatf("wr_spacing%0d", i), wr_cyc[wb+i] - wr_cyc[wb+i-1], 2 + v.gap);
      end
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int wb = wr_addr.size();
    int db = done_n;
    do_start(v.sa);
    for (int i = 0; i < WORDS; i++) offer(v.d[i], v.gap, v.restart && (i == 1));
    wait_done();
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    repeat (2) @(negedge clk);
    check_log(v, wb, db);
    for (int i = 0; i < WORDS; i++) check_ram(v.ea[i], v.d[i]);
  endtask

  initial begin
    vec_t v1, v2;
    int wb, db;

    vecs[0] = mk(4'd0,  32'h44332211, {4'd3, 4'd2, 4'd1, 4'd0},      0, 1'b0);
    vecs[1] = mk(4'd14, 32'hA3A2A1A0, {4'd1, 4'd0, 4'd15, 4'd14},    0, 1'b0);
    vecs[2] = mk(4'd4,  32'h54535251, {4'd7, 4'd6, 4'd5, 4'd4},      5, 1'b0);
    vecs[3] = mk(4'd9,  32'h64636261, {4'd12, 4'd11, 4'd10, 4'd9},   0, 1'b1);

    @(negedge clk);
    check("rst_ready", data_ready, 1'b0);
    check("rst_write", mem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", address_to_memory, 4'd0);
    check("rst_data", data_to_memory, 8'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_xfer(vecs[k]);
      @(negedge clk);
    end

    // Back-to-back: start held through FINISH (ignored) into the following IDLE cycle.
    v1 = mk(4'd2,  32'h74737271, {4'd5, 4'd4, 4'd3, 4'd2},     0, 1'b0);
    v2 = mk(4'd12, 32'h84838281, {4'd15, 4'd14, 4'd13, 4'd12}, 0, 1'b0);
    wb = wr_addr.size();
    db = done_n;
    do_start(v1.sa);
    for (int i = 0; i < WORDS; i++) offer(v1.d[i], 0, 1'b0);
    wait_done();
    start = 1'b1;
    start_address = v2.sa;
    @(negedge clk);
    check("finish_start_ignored", busy, 1'b0);
    check_log(v1, wb, db);
    wb = wr_addr.size();
    db = done_n;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    for (int i = 0; i < WORDS; i++) offer(v2.d[i], 0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check_log(v2, wb, db);
    for (int i = 0; i < WORDS; i++) check_ram(v2.ea[i], v2.d[i]);
    @(negedge clk);

    // Reset after two writes at address 4: later entries must never reach memory.
    wb = wr_addr.size();
    db = done_n;
    do_start(4'd4);
    offer(8'hC1, 0, 1'b0);
    offer(8'hC2, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", data_ready, 1'b0);
    check("abort_write", mem_write, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_addr", address_to_memory, 4'd0);
    check("abort_data", data_to_memory, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_write_count", wr_addr.size() - wb, 2);
    check("abort_no_done", done_n - db, 0);
    check_ram(4'd4, 8'hC1);
    check_ram(4'd5, 8'hC2);
    check_ram(4'd6, 8'h53);
    check_ram(4'd7, 8'h54);

    @(negedge clk);
    data_valid = 1'b1;
    data_in = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_low", data_ready, 1'b0);
      check("idle_no_write", mem_write, 1'b0);
    end
    data_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_writer.md
MATRIX_WRITER -- requirements
Module: matrix_writer

Interface
REQ-001 Parameter WORDS, default 4, sets the number of 8-bit matrix entries written per transfer (2x2 matrix).
REQ-002 Parameter AW, default 4, sets the memory address width (16-entry memory).
REQ-003 Port clk  input  1  sets the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-low reset.
REQ-005 Port start  input  1  is a one-cycle request to begin a transfer.
REQ-006 Port start_address  input  AW  is the first memory address of the transfer, sampled with start.
REQ-007 Port data_in  input  8  is the matrix entry offered by the source.
REQ-008 Port data_valid  input  1  means data_in holds a valid entry.
REQ-009 Port data_ready  output  1  means the block accepts data_in this cycle.
REQ-010 Port address_to_memory  output  AW  is the memory write address.
REQ-011 Port data_to_memory  output  8  is the memory write data.
REQ-012 Port mem_write  output  1  is the memory write enable, one cycle per entry.
REQ-013 Port busy  output  1  is high from the start acceptance until done.
REQ-014 Port done  output  1  is a one-cycle pulse after the last write.

Function
REQ-015 The FSM SHALL have the states IDLE, RECV, WRITE and FINISH.
REQ-016 IDLE: on start=1, latch start_address into addr, clear count, and go to RECV next cycle; busy=1 from that cycle.
REQ-017 RECV: data_ready=1; on data_valid=1, register data_in and go to WRITE; otherwise stay in RECV indefinitely.
REQ-018 WRITE: mem_write=1, address_to_memory=addr, data_to_memory=registered byte, data_ready=0, for exactly one cycle.
REQ-019 WRITE exit: addr increments modulo 2^AW (15 wraps to 0) and count increments; go to FINISH if count was WORDS-1, else RECV.
REQ-020 FINISH: done=1 and busy=0 for one cycle, then IDLE.
REQ-021 Latency from an accepted entry to its write SHALL be 1 cycle; sustained throughput is one entry per 2 cycles.
REQ-022 start SHALL be ignored in every state except IDLE; start in the FINISH cycle SHALL also be ignored.
REQ-023 data_valid SHALL be ignored outside RECV, and data_ready SHALL be 0 outside RECV.
REQ-024 count SHALL be wide enough for WORDS (clog2(WORDS+1) bits); no overflow for any WORDS up to 2^AW.
REQ-025 WORDS greater than 2^AW SHALL overwrite wrapped addresses in order without error.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, with addr=0, count=0, data register=0.
REQ-027 During reset, all outputs SHALL be 0 (data_ready, mem_write, busy, done, address_to_memory, data_to_memory).
REQ-028 Reset mid-transfer SHALL abort it with no further write and no done pulse; completed writes remain in memory.
REQ-029 After reset release, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RECV, WRITE, FINISH) and the default WORDS/AW constants.
REQ-031 One sub-module, ram16x8 (synchronous write, combinational read), is natural for the bench and top level and SHALL sit outside matrix_writer.
REQ-032 matrix_writer SHALL contain only the FSM, the address/count registers and the data register.

Verification
REQ-033 start, start_address=0, entries 0x11,0x22,0x33,0x44 offered back-to-back -> RAM[0..3]=11,22,33,44; mem_write pulses 4 times, 2 cycles apart; one done pulse.
REQ-034 start_address=14, entries 0xA0..0xA3 -> RAM[14]=A0, RAM[15]=A1, RAM[0]=A2, RAM[1]=A3 (wrap-around).
REQ-035 data_valid low for 5 cycles between entries -> block holds in RECV with data_ready=1; no spurious mem_write; final RAM contents are correct.
REQ-036 Second start asserted while busy, with start_address=8 -> ignored; writes continue at the original addresses; exactly one done pulse.
REQ-037 reset=0 after 2 entries written at address 4 -> RAM[4..5] written, RAM[6..7] untouched, no done pulse, all outputs 0 at once.
REQ-038 Back-to-back transfers (start the cycle after done) -> the second transfer writes correctly from its new start_address.
